// File: rtl/stream_record_extractor_if.sv
// Record-extractor bus: byte-stream beats in, left-aligned records out.
// master = stream producer / record consumer, slave = the extractor.
interface stream_record_extractor_if #(
    parameter int DATA_BUS_WIDTH_BYTES = 8,
    parameter int MAX_RECORD_BYTES     = 34
);
    logic [DATA_BUS_WIDTH_BYTES*8-1:0]       dataIn;
    logic                                    dataInValid;
    logic                                    dataInReady;
    logic [MAX_RECORD_BYTES*8-1:0]           recordOut;
    logic [$clog2(MAX_RECORD_BYTES+1)-1:0]   recordLength;
    logic                                    recordError;
    logic                                    recordValid;
    logic                                    recordReady;

    modport master (
        output dataIn, dataInValid, recordReady,
        input  dataInReady, recordOut, recordLength, recordError, recordValid
    );

    modport slave (
        input  dataIn, dataInValid, recordReady,
        output dataInReady, recordOut, recordLength, recordError, recordValid
    );
endinterface

// File: rtl/stream_record_extractor.sv
// Pulls delimiter-terminated records off a byte stream and presents each left-aligned.
// Define STREAM_RECORD_STATS_EN to add saturating recordCount/errorCount outputs.
module stream_record_extractor #(
    parameter int         DATA_BUS_WIDTH_BYTES     = 8,
    parameter int         MAX_VARIABLEFIELD_LENGTH = 16,
    parameter int         FIXEDFIELD_LENGTH_BYTES  = 17,
    parameter logic [7:0] VARIABLEFIELD_DELIMITER  = 8'h2c
) (
    input  logic        clk,
    input  logic        resetn,
`ifdef STREAM_RECORD_STATS_EN
    output logic [31:0] recordCount,
    output logic [31:0] errorCount,
`endif
    stream_record_extractor_if.slave bus
);
    localparam int MAX_RECORD_BYTES = MAX_VARIABLEFIELD_LENGTH + 1 + FIXEDFIELD_LENGTH_BYTES;
    localparam int BUF_BYTES        = MAX_RECORD_BYTES + DATA_BUS_WIDTH_BYTES;
    localparam int BUF_BITS         = BUF_BYTES * 8;
    localparam int REC_BITS         = MAX_RECORD_BYTES * 8;
    localparam int IDX_W            = $clog2(BUF_BYTES + 1);
    localparam int LEN_W            = $clog2(MAX_RECORD_BYTES + 1);

    localparam logic [IDX_W-1:0] BEAT        = IDX_W'(DATA_BUS_WIDTH_BYTES);
    localparam logic [IDX_W-1:0] READY_LIMIT = IDX_W'(BUF_BYTES - DATA_BUS_WIDTH_BYTES);
    localparam logic [IDX_W-1:0] FIELD_TAIL  = IDX_W'(FIXEDFIELD_LENGTH_BYTES + 1);
    localparam logic [IDX_W-1:0] VF_MAX      = IDX_W'(MAX_VARIABLEFIELD_LENGTH);
    localparam logic [IDX_W-1:0] BUF_MAX     = IDX_W'(BUF_BYTES);
    localparam logic [LEN_W-1:0] TRUNC_LEN   = LEN_W'(MAX_VARIABLEFIELD_LENGTH + 1);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t             state, stateNext;
    logic [BUF_BITS-1:0] bufData, bufNext;
    logic [IDX_W-1:0]   fillBytes, fillNext;
    logic               resetnQ;
    logic               recordValid, validNext;
    logic [LEN_W-1:0]   recordLength, lengthNext;
    logic               recordError, errorNext;
    logic               accept, pop;
    logic               delimFound, recComplete, recTruncated;
    logic [IDX_W-1:0]   delimPos, needLen, popLen, baseFill;

    assign bus.dataInReady  = resetnQ && (fillBytes <= READY_LIMIT);
    assign bus.recordValid  = recordValid;
    assign bus.recordLength = recordLength;
    assign bus.recordError  = recordError;
    // Buffer bytes past recordLength may already hold the next record; hide them.
    assign bus.recordOut    = bufData[REC_BITS-1:0] & ~({REC_BITS{1'b1}} << {recordLength, 3'b000});

    assign accept = bus.dataInValid && bus.dataInReady;
    assign pop    = recordValid && bus.recordReady;

    // Descending scan so the lowest-index delimiter wins.
    always_comb begin
        delimFound = 1'b0;
        delimPos   = '0;
        for (int d = MAX_VARIABLEFIELD_LENGTH; d >= 0; d--) begin
            if ((IDX_W'(d) < fillBytes) && (bufData[d*8 +: 8] == VARIABLEFIELD_DELIMITER)) begin
                delimFound = 1'b1;
                delimPos   = IDX_W'(d);
            end
        end
    end

    assign needLen      = delimPos + FIELD_TAIL;
    assign recComplete  = delimFound && (fillBytes >= needLen);
    assign recTruncated = !delimFound && (fillBytes > VF_MAX);

    // Pop realigns by a full barrel shift; a concurrent beat lands just above the survivors.
    always_comb begin
        popLen   = pop ? IDX_W'(recordLength) : '0;
        baseFill = fillBytes - popLen;
        fillNext = baseFill + (accept ? BEAT : '0);
        bufNext  = bufData >> {popLen, 3'b000};
        if (accept) begin
            bufNext = bufNext | (BUF_BITS'(bus.dataIn) << {baseFill, 3'b000});
        end
        bufNext  = bufNext & ~({BUF_BITS{1'b1}} << {fillNext, 3'b000});
    end

    always_comb begin
        stateNext  = state;
        validNext  = recordValid;
        lengthNext = recordLength;
        errorNext  = recordError;
        case (state)
            ACCUM: begin
                if (recComplete) begin
                    stateNext  = EMIT;
                    validNext  = 1'b1;
                    lengthNext = LEN_W'(needLen);
                    errorNext  = 1'b0;
                end else if (recTruncated) begin
                    stateNext  = EMIT;
                    validNext  = 1'b1;
                    lengthNext = TRUNC_LEN;
                    errorNext  = 1'b1;
                end
            end
            EMIT: begin
                if (bus.recordReady) begin
                    stateNext  = ACCUM;
                    validNext  = 1'b0;
                    lengthNext = '0;
                    errorNext  = 1'b0;
                end
            end
            default: stateNext = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        resetnQ <= resetn;
        if (!resetn) begin
            state        <= ACCUM;
            bufData      <= '0;
            fillBytes    <= '0;
            recordValid  <= 1'b0;
            recordLength <= '0;
            recordError  <= 1'b0;
        end else begin
            state        <= stateNext;
            bufData      <= bufNext;
            fillBytes    <= fillNext;
            recordValid  <= validNext;
            recordLength <= lengthNext;
            recordError  <= errorNext;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (fillBytes <= BUF_MAX);
        end
    end

`ifdef STREAM_RECORD_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            recordCount <= '0;
            errorCount  <= '0;
        end else if (pop) begin
            if (recordCount != 32'hFFFF_FFFF) recordCount <= recordCount + 32'd1;
            if (recordError && (errorCount != 32'hFFFF_FFFF)) errorCount <= errorCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stream_record_extractor.sv
// Directed bench for stream_record_extractor: latency, boundaries, truncation, backpressure, reset.
module tb_stream_record_extractor;
    localparam int W      = 8;
    localparam int MAXREC = 34;
    localparam int RB     = MAXREC * 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    stream_record_extractor_if #(.DATA_BUS_WIDTH_BYTES(W), .MAX_RECORD_BYTES(MAXREC)) bus ();
`ifdef STREAM_RECORD_STATS_EN
    logic [31:0] recordCount, errorCount;
`endif

    stream_record_extractor dut (
        .clk(clk),
        .resetn(resetn),
`ifdef STREAM_RECORD_STATS_EN
        .recordCount(recordCount),
        .errorCount(errorCount),
`endif
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] txq[$];
    logic [7:0] refs[$];
    int refPos = 0;
    bit feedEn = 0;
    int cyc = 0;
    int beats = 0;
    int accCyc[64];
    int validCyc = 0;
    int popCyc = 0;

    task automatic check(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        if (feedEn && txq.size() >= W) begin
            for (int i = 0; i < W; i++) bus.dataIn[i*8 +: 8] = txq[i];
            bus.dataInValid = 1'b1;
        end else begin
            bus.dataIn = '0;
            bus.dataInValid = 1'b0;
        end
    endtask

    task automatic tick();
        bit acc;
        acc = bus.dataInValid && bus.dataInReady;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            repeat (W) void'(txq.pop_front());
            beats++;
            if (beats < 64) accCyc[beats] = cyc;
        end
        drive();
    endtask

    task automatic pushByte(input logic [7:0] b);
        txq.push_back(b);
        refs.push_back(b);
    endtask

    task automatic pushStd();
        for (int i = 0; i < 5; i++) pushByte(8'h41 + 8'(i));
        pushByte(8'h2c);
        for (int i = 0; i < 17; i++) pushByte(8'h11);
    endtask

    task automatic startFeed();
        feedEn = 1;
        beats = 0;
        drive();
    endtask

    task automatic doReset();
        feedEn = 0;
        txq.delete();
        refs.delete();
        refPos = 0;
        bus.recordReady = 1'b0;
        drive();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic waitValid(input string tag, input int maxCycles);
        int n = 0;
        while (bus.recordValid !== 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        validCyc = cyc;
        check({tag, "_valid"}, bus.recordValid, 1'b1);
    endtask

    task automatic checkRecord(input string tag, input int len, input logic err);
        logic [RB-1:0] exp;
        exp = '0;
        for (int i = 0; i < len; i++) exp[i*8 +: 8] = refs[refPos + i];
        check({tag, "_len"}, bus.recordLength, len);
        check({tag, "_err"}, bus.recordError, err);
        check({tag, "_data"}, bus.recordOut, exp);
    endtask

    task automatic popRecord(input int len);
        bus.recordReady = 1'b1;
        tick();
        bus.recordReady = 1'b0;
        refPos += len;
        popCyc = cyc;
    endtask

    initial begin
        bus.dataIn = '0;
        bus.dataInValid = 1'b0;
        bus.recordReady = 1'b0;

        // Reset state, then two back-to-back 23-byte records with exact timing.
        doReset();
        check("rst_valid", bus.recordValid, 1'b0);
        check("rst_len", bus.recordLength, 0);
        check("rst_err", bus.recordError, 1'b0);
        check("rst_ready", bus.dataInReady, 1'b1);
        pushStd();
        pushStd();
        pushByte(8'h00);
        pushByte(8'h00);
        startFeed();
        waitValid("t1_r0", 20);
        check("t1_latency", validCyc - accCyc[3], 1);
        checkRecord("t1_r0", 23, 1'b0);
        popRecord(23);
        waitValid("t1_r1", 20);
        check("t1_spacing", validCyc - popCyc, 2);
        checkRecord("t1_r1", 23, 1'b0);
        popRecord(23);

        // Empty variable field (18 B) followed by a maximal record (34 B).
        doReset();
        pushByte(8'h2c);
        for (int i = 0; i < 17; i++) pushByte(8'h30 + 8'(i));
        for (int i = 0; i < 16; i++) pushByte(8'h61 + 8'(i));
        pushByte(8'h2c);
        for (int i = 0; i < 17; i++) pushByte((i < 16) ? 8'h70 + 8'(i) : 8'h5a);
        repeat (4) pushByte(8'h00);
        startFeed();
        waitValid("t2_r0", 20);
        checkRecord("t2_r0", 18, 1'b0);
        check("t2_mask", bus.recordOut[18*8 +: 8], 8'h00);
        popRecord(18);
        waitValid("t2_r1", 20);
        checkRecord("t2_r1", 34, 1'b0);
        check("t2_last", bus.recordOut[33*8 +: 8], 8'h5a);
        popRecord(34);

        // 20 delimiter-free bytes force a truncated record, then parsing resumes at byte 17.
        doReset();
        for (int i = 0; i < 20; i++) pushByte(8'h41 + 8'(i));
        pushStd();
        repeat (5) pushByte(8'h00);
        startFeed();
        waitValid("t3_r0", 20);
        checkRecord("t3_r0", 17, 1'b1);
        popRecord(17);
        waitValid("t3_r1", 20);
        checkRecord("t3_r1", 26, 1'b0);
        popRecord(26);
`ifdef STREAM_RECORD_STATS_EN
        check("t3_recordCount", recordCount, 2);
        check("t3_errorCount", errorCount, 1);
`endif

        // Consumer stalls 20 cycles; input backs up, then recovers with nothing lost.
        doReset();
        pushStd();
        pushStd();
        pushStd();
        repeat (3) pushByte(8'h00);
        startFeed();
        waitValid("t4_r0", 20);
        checkRecord("t4_r0", 23, 1'b0);
        repeat (20) tick();
        check("t4_stall_ready", bus.dataInReady, 1'b0);
        check("t4_stall_valid", bus.recordValid, 1'b1);
        check("t4_stall_len", bus.recordLength, 23);
        popRecord(23);
        check("t4_ready_back", bus.dataInReady, 1'b1);
        waitValid("t4_r1", 20);
        checkRecord("t4_r1", 23, 1'b0);
        popRecord(23);
        waitValid("t4_r2", 20);
        checkRecord("t4_r2", 23, 1'b0);
        popRecord(23);

        // Delimiters inside the fixed field are data, not terminators.
        doReset();
        for (int i = 0; i < 5; i++) pushByte(8'h41 + 8'(i));
        pushByte(8'h2c);
        for (int i = 0; i < 17; i++) pushByte((i % 2 == 0) ? 8'h2c : 8'h33);
        pushByte(8'h00);
        startFeed();
        waitValid("t5_r0", 20);
        checkRecord("t5_r0", 23, 1'b0);
        popRecord(23);

        // Reset while a record is pending drops it; next record comes from fresh data only.
        doReset();
        pushStd();
        pushStd();
        pushByte(8'h00);
        pushByte(8'h00);
        startFeed();
        waitValid("t6_pre", 20);
        feedEn = 0;
        drive();
        resetn = 1'b0;
        tick();
        check("t6_valid", bus.recordValid, 1'b0);
        check("t6_len", bus.recordLength, 0);
        check("t6_err", bus.recordError, 1'b0);
        check("t6_ready", bus.dataInReady, 1'b0);
`ifdef STREAM_RECORD_STATS_EN
        check("t6_recordCount", recordCount, 0);
        check("t6_errorCount", errorCount, 0);
`endif
        resetn = 1'b1;
        tick();
        txq.delete();
        refs.delete();
        refPos = 0;
        pushByte(8'h58);
        pushByte(8'h59);
        pushByte(8'h2c);
        for (int i = 0; i < 17; i++) pushByte(8'h22);
        repeat (4) pushByte(8'h00);
        startFeed();
        waitValid("t6_r0", 20);
        checkRecord("t6_r0", 20, 1'b0);
        popRecord(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
